// File: rtl/aggr_pkg.sv
// Shared definitions for the two-engine aggregator/distributor pair:
// engine ids, header/body state encoding and the header beat-count rule.
package aggr_pkg;

  localparam logic ENGINE1 = 1'b0;
  localparam logic ENGINE2 = 1'b1;

  localparam int BYTES_PER_BEAT = 8;

  typedef enum logic {
    HEAD = 1'b0,
    BODY = 1'b1
  } dist_state_e;

  // Beats occupied by a packet of len bytes; an empty packet still takes one beat.
  function automatic logic [63:0] beat_count(input logic [63:0] len);
    logic [63:0] n;
    n = (len + 64'(BYTES_PER_BEAT - 1)) >> $clog2(BYTES_PER_BEAT);
    if (n == 64'd0) n = 64'd1;
    return n;
  endfunction

endpackage

// File: rtl/dist_out_reg.sv
// One-entry output register steering a held beat to engine 1 or engine 2;
// reloads in the same cycle it drains, so throughput is one beat per cycle.
module dist_out_reg
  import aggr_pkg::*;
#(
  parameter int DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_dest,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  out1_valid,
  output logic                  out1_last,
  input  logic                  out1_ready,
  output logic                  out2_valid,
  output logic                  out2_last,
  input  logic                  out2_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  dest_q, dest_d;
  logic                  last_q, last_d;
  logic                  dest_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      dest_q  <= ENGINE1;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      dest_q  <= dest_d;
      last_q  <= last_d;
    end
  end

  // Only the engine the held beat is addressed to can release the register.
  assign dest_ready = (dest_q == ENGINE1) ? out1_ready : out2_ready;
  assign in_ready   = !valid_q || dest_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    dest_d  = dest_q;
    last_d  = last_q;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
      dest_d  = in_dest;
      last_d  = in_last;
    end else if (valid_q && dest_ready) begin
      valid_d = 1'b0;
    end
  end

  assign out1_valid = valid_q && (dest_q == ENGINE1);
  assign out2_valid = valid_q && (dest_q == ENGINE2);
  assign out1_last  = last_q && out1_valid;
  assign out2_last  = last_q && out2_valid;
  assign out_data   = data_q;

endmodule

// File: rtl/packet_distributor.sv
// Splits one packet stream across two engines, alternating whole packets;
// packet length is taken from the header beat's low LENGTH_WIDTH bits.
module packet_distributor
  import aggr_pkg::*;
#(
  parameter int DATA_WIDTH   = 256,
  parameter int LENGTH_WIDTH = 32,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out1_valid,
  output logic [DATA_WIDTH-1:0] out1_data,
  output logic                  out1_last,
  input  logic                  out1_ready,
  output logic                  out2_valid,
  output logic [DATA_WIDTH-1:0] out2_data,
  output logic                  out2_last,
  input  logic                  out2_ready,
  output logic [CNT_WIDTH-1:0]  pkt_cnt1,
  output logic [CNT_WIDTH-1:0]  pkt_cnt2
);

  localparam int REM_W = LENGTH_WIDTH - 2;
  localparam logic [REM_W-1:0]     REM_ONE = REM_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  dist_state_e           state_q, state_d;
  logic [REM_W-1:0]      rem_q, rem_d;
  logic                  sel_q, sel_d;
  logic [CNT_WIDTH-1:0]  cnt1_q, cnt1_d;
  logic [CNT_WIDTH-1:0]  cnt2_q, cnt2_d;
  logic [63:0]           n_full;
  logic                  accept;
  logic                  beat_last;
  logic [DATA_WIDTH-1:0] out_data;

  assign n_full = beat_count(64'(in_data[LENGTH_WIDTH-1:0]));
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HEAD;
      rem_q   <= '0;
      sel_q   <= ENGINE1;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sel_q   <= sel_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sel_d   = sel_q;
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    if (accept) begin
      unique case (state_q)
        HEAD: begin
          if (!beat_last) begin
            rem_d   = n_full[REM_W-1:0] - REM_ONE;
            state_d = BODY;
          end
        end
        BODY: begin
          if (beat_last) state_d = HEAD;
          else           rem_d   = rem_q - REM_ONE;
        end
        default: state_d = HEAD;
      endcase
      // A packet is counted once its final beat has been taken in.
      if (beat_last) begin
        sel_d = ~sel_q;
        if (sel_q == ENGINE1) cnt1_d = cnt1_q + CNT_ONE;
        else                  cnt2_d = cnt2_q + CNT_ONE;
      end
    end
  end

  always_comb begin
    beat_last = 1'b0;
    unique case (state_q)
      HEAD:    beat_last = (n_full == 64'd1);
      BODY:    beat_last = (rem_q == REM_ONE);
      default: beat_last = 1'b0;
    endcase
  end

  dist_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_dest   (sel_q),
    .in_last   (beat_last),
    .in_ready  (in_ready),
    .out1_valid(out1_valid),
    .out1_last (out1_last),
    .out1_ready(out1_ready),
    .out2_valid(out2_valid),
    .out2_last (out2_last),
    .out2_ready(out2_ready),
    .out_data  (out_data)
  );

  assign out1_data = out_data;
  assign out2_data = out_data;
  assign pkt_cnt1  = cnt1_q;
  assign pkt_cnt2  = cnt2_q;

endmodule

// File: tb/tb_packet_distributor.sv
// Bench for packet_distributor: packets are modelled as whole units that
// alternate between engines; every beat drained is matched against that model.
module tb_packet_distributor;

  localparam int DW = 256;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out1_valid, out1_last, out1_ready;
  logic          out2_valid, out2_last, out2_ready;
  logic [DW-1:0] out1_data, out2_data;
  logic [15:0]   pkt_cnt1, pkt_cnt2;

  packet_distributor #(
    .DATA_WIDTH  (DW),
    .LENGTH_WIDTH(32),
    .CNT_WIDTH   (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out1_valid(out1_valid),
    .out1_data (out1_data),
    .out1_last (out1_last),
    .out1_ready(out1_ready),
    .out2_valid(out2_valid),
    .out2_data (out2_data),
    .out2_last (out2_last),
    .out2_ready(out2_ready),
    .pkt_cnt1  (pkt_cnt1),
    .pkt_cnt2  (pkt_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int            len_q[$];
  beat_t         exp_q1[$];
  beat_t         exp_q2[$];
  bit            drv_active;
  int            drv_len, drv_nb, drv_idx;
  bit            drv_eng;
  logic [15:0]   m_cnt1, m_cnt2;
  logic [DW-1:0] cur_data;
  int            n_acc;
  int            p_valid, p_rdy1, p_rdy2;
  bit            stall1, stall2;
  logic [DW-1:0] hold_d1, hold_d2;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd256();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic gen_beat();
    cur_data = rnd256();
    if (drv_idx == 0) cur_data[31:0] = 32'(drv_len);
  endtask

  task automatic drive();
    if (!drv_active && len_q.size() > 0) begin
      drv_len = len_q.pop_front();
      drv_nb  = (drv_len + 7) / 8;
      if (drv_nb == 0) drv_nb = 1;
      drv_idx    = 0;
      drv_active = 1'b1;
      gen_beat();
    end
    in_valid   = drv_active && ($urandom_range(99) < p_valid);
    in_data    = cur_data;
    out1_ready = ($urandom_range(99) < p_rdy1);
    out2_ready = ($urandom_range(99) < p_rdy2);
  endtask

  task automatic flush_model();
    len_q.delete();
    exp_q1.delete();
    exp_q2.delete();
    drv_active = 1'b0;
    drv_eng    = 1'b0;
    m_cnt1     = '0;
    m_cnt2     = '0;
    stall1     = 1'b0;
    stall2     = 1'b0;
  endtask

  task automatic check_drain(input int eng, input logic [DW-1:0] data, input logic last);
    beat_t b;
    if (eng == 1) begin
      if (exp_q1.size() == 0) begin
        chk("out1_unexpected_beat", 1, 0);
        return;
      end
      b = exp_q1.pop_front();
      chk("out1_data", data, b.d);
      chk("out1_last", DW'(last), DW'(b.l));
    end else begin
      if (exp_q2.size() == 0) begin
        chk("out2_unexpected_beat", 1, 0);
        return;
      end
      b = exp_q2.pop_front();
      chk("out2_data", data, b.d);
      chk("out2_last", DW'(last), DW'(b.l));
    end
  endtask

  task automatic step();
    bit    acc;
    beat_t b;
    acc = 1'b0;
    @(negedge clk);
    chk("pkt_cnt1", DW'(pkt_cnt1), DW'(m_cnt1));
    chk("pkt_cnt2", DW'(pkt_cnt2), DW'(m_cnt2));
    chk("both_valid", DW'(out1_valid && out2_valid), 0);
    chk("out1_last_without_valid", DW'(out1_last && !out1_valid), 0);
    chk("out2_last_without_valid", DW'(out2_last && !out2_valid), 0);
    if (stall1 && out1_valid) chk("out1_hold", out1_data, hold_d1);
    if (stall2 && out2_valid) chk("out2_hold", out2_data, hold_d2);
    if (!out1_valid && !out2_valid) chk("in_ready_empty", DW'(in_ready), 1);
    else if (out1_valid)            chk("in_ready_eng1", DW'(in_ready), DW'(out1_ready));
    else                            chk("in_ready_eng2", DW'(in_ready), DW'(out2_ready));
    if (out1_valid && out1_ready) check_drain(1, out1_data, out1_last);
    if (out2_valid && out2_ready) check_drain(2, out2_data, out2_last);
    stall1  = out1_valid && !out1_ready;
    stall2  = out2_valid && !out2_ready;
    hold_d1 = out1_data;
    hold_d2 = out2_data;
    if (in_valid && in_ready) begin
      acc = 1'b1;
      n_acc++;
      b.d = in_data;
      b.l = (drv_idx == drv_nb - 1);
      if (drv_eng == 1'b0) exp_q1.push_back(b);
      else                 exp_q2.push_back(b);
      if (b.l) begin
        if (drv_eng == 1'b0) m_cnt1 = m_cnt1 + 16'd1;
        else                 m_cnt2 = m_cnt2 + 16'd1;
        drv_eng = ~drv_eng;
      end
    end
    @(posedge clk);
    #1;
    if (acc) begin
      drv_idx++;
      if (drv_idx == drv_nb) drv_active = 1'b0;
      else                   gen_beat();
    end
    drive();
  endtask

  task automatic run_phase(input int budget);
    int c;
    c = 0;
    while ((drv_active || len_q.size() > 0 || exp_q1.size() > 0 || exp_q2.size() > 0)
           && c < budget) begin
      step();
      c++;
    end
    if (c >= budget) chk("phase_timeout", 1, 0);
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    flush_model();
    @(negedge clk);
    chk("rst_in_ready", DW'(in_ready), 1);
    chk("rst_out1_valid", DW'(out1_valid), 0);
    chk("rst_out2_valid", DW'(out2_valid), 0);
    chk("rst_out1_last", DW'(out1_last), 0);
    chk("rst_out2_last", DW'(out2_last), 0);
    chk("rst_data", out1_data, 0);
    chk("rst_pkt_cnt1", DW'(pkt_cnt1), 0);
    chk("rst_pkt_cnt2", DW'(pkt_cnt2), 0);
    @(posedge clk);
    #1;
    drive();
  endtask

  initial begin
    int base;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    out1_ready = 1'b0;
    out2_ready = 1'b0;
    cur_data   = '0;
    n_acc      = 0;
    p_valid    = 100;
    p_rdy1     = 100;
    p_rdy2     = 100;
    flush_model();
    repeat (2) @(posedge clk);
    #1;
    apply_reset();

    // Single-beat packets, then a 3-beat packet followed by a single beat
    len_q.push_back(5);
    len_q.push_back(8);
    run_phase(50);
    chk("single_cnt1", DW'(pkt_cnt1), 1);
    chk("single_cnt2", DW'(pkt_cnt2), 1);
    len_q.push_back(20);
    len_q.push_back(3);
    run_phase(50);

    // Engine 1 stalls while a 3-beat packet is in flight
    len_q.push_back(24);
    p_rdy1 = 0;
    repeat (4) step();
    p_rdy1 = 100;
    run_phase(50);

    // Zero-length header, then ten back-to-back single-beat packets
    len_q.push_back(0);
    run_phase(50);
    base = 0;
    for (int i = 0; i < 10; i++) len_q.push_back($urandom_range(8));
    run_phase(100);

    // Random lengths with random valid/ready gaps
    p_valid = 70;
    p_rdy1  = 60;
    p_rdy2  = 60;
    for (int i = 0; i < 150; i++) len_q.push_back($urandom_range(64));
    run_phase(20000);

    // Reset two beats into a 5-beat packet, then a fresh header
    p_valid = 100;
    p_rdy1  = 100;
    p_rdy2  = 100;
    len_q.push_back(40);
    base = n_acc;
    for (int c = 0; c < 50 && n_acc - base < 2; c++) step();
    if (n_acc - base < 2) chk("midpkt_timeout", 1, 0);
    apply_reset();
    len_q.push_back(8);
    run_phase(50);
    chk("after_rst_cnt1", DW'(pkt_cnt1), 1);
    chk("after_rst_cnt2", DW'(pkt_cnt2), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
